// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the program loader
package lc_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam int         FRAME_HDR_BYTES = 2;
    localparam int         BYTES_PER_WORD  = 2;
    localparam logic [7:0] CSUM_INIT       = 8'h00;

    // States in which the loader takes a byte from the upstream source
    function automatic logic takes_byte(loader_state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
               (s == ST_DATA_LO) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_timer.sv
// rtl/prog_loader_timer.sv - inter-byte idle timeout counter
module loader_timer #(
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int            CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader writing a program image into cpu memory
module prog_loader
    import lc_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int WORD_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  mem_wr,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

    loader_state_t         state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic [7:0]            csum_q, csum_d;
    logic                  accept;
    logic                  expired;

    assign accept = rx_ready && rx_valid;

    loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clear_i  (accept || !busy),
        .enable_i (rx_ready),
        .expired_o(expired)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wdata_d  = wdata_q;
        words_d  = words_q;
        csum_d   = csum_q;
        rx_ready = takes_byte(state_q);
        busy     = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
        mem_wr   = (state_q == ST_WRITE);
        done     = (state_q == ST_DONE);
        err      = (state_q == ST_ERR);
        cpu_rst  = (state_q != ST_IDLE) && (state_q != ST_DONE);

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    words_d = '0;
                    csum_d  = CSUM_INIT;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d   = {rx_data, 8'h00};
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d  = {len_q[15:8], rx_data};
                    csum_d = csum_q ^ rx_data;
                    // An oversize image is rejected here so the address can never wrap
                    if ({len_q[15:8], rx_data} == 16'h0000) begin
                        state_d = ST_CSUM;
                    end else if (33'({len_q[15:8], rx_data}) > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    wdata_d = WORD_WIDTH'({rx_data, 8'h00});
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    wdata_d[7:0] = rx_data;
                    csum_d       = csum_q ^ rx_data;
                    state_d      = ST_WRITE;
                end
            end
            ST_WRITE: begin
                words_d = words_q + 1'b1;
                if ((33'(words_q) + 33'd1) < 33'(len_q)) begin
                    state_d = ST_DATA_HI;
                end else begin
                    state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rx_ready && !accept && expired) begin
            state_d = ST_ERR;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            wdata_q <= '0;
            words_q <= '0;
            csum_q  <= CSUM_INIT;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            words_q <= words_d;
            csum_q  <= csum_d;
        end
    end

    assign mem_addr     = words_q[ADDR_WIDTH-1:0];
    assign mem_wdata    = wdata_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader
module tb_prog_loader;

    localparam int TO = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       sel = 1'b0;

    always #5 CLK = ~CLK;

    logic        rdy_a, wr_a, cr_a, busy_a, done_a, err_a;
    logic [15:0] addr_a, wd_a;
    logic [16:0] wl_a;
    logic        rdy_b, wr_b, cr_b, busy_b, done_b, err_b;
    logic [3:0]  addr_b;
    logic [15:0] wd_b;
    logic [4:0]  wl_b;

    prog_loader #(.ADDR_WIDTH(16), .WORD_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut_a (
        .CLK(CLK), .RST(RST), .start(start && !sel), .rx_data(rx_data),
        .rx_valid(rx_valid && !sel), .rx_ready(rdy_a), .mem_addr(addr_a),
        .mem_wdata(wd_a), .mem_wr(wr_a), .cpu_rst(cr_a), .busy(busy_a),
        .done(done_a), .err(err_a), .words_loaded(wl_a)
    );

    prog_loader #(.ADDR_WIDTH(4), .WORD_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut_b (
        .CLK(CLK), .RST(RST), .start(start && sel), .rx_data(rx_data),
        .rx_valid(rx_valid && sel), .rx_ready(rdy_b), .mem_addr(addr_b),
        .mem_wdata(wd_b), .mem_wr(wr_b), .cpu_rst(cr_b), .busy(busy_b),
        .done(done_b), .err(err_b), .words_loaded(wl_b)
    );

    logic        c_rdy, c_cpu, c_busy, c_done, c_err;
    logic [16:0] c_wl;
    logic [15:0] c_addr, c_wd;
    assign c_rdy  = sel ? rdy_b  : rdy_a;
    assign c_cpu  = sel ? cr_b   : cr_a;
    assign c_busy = sel ? busy_b : busy_a;
    assign c_done = sel ? done_b : done_a;
    assign c_err  = sel ? err_b  : err_a;
    assign c_wl   = sel ? 17'(wl_b) : wl_a;
    assign c_addr = sel ? 16'(addr_b) : addr_a;
    assign c_wd   = sel ? wd_b : wd_a;

    int          wr_addr[$];
    logic [15:0] wr_data[$];
    int          acc_cnt;

    always @(negedge CLK) begin
        if (wr_a) begin
            wr_addr.push_back(int'(addr_a));
            wr_data.push_back(wd_a);
        end
        if (wr_b) begin
            wr_addr.push_back(int'(addr_b));
            wr_data.push_back(wd_b);
        end
        if (c_rdy && rx_valid) acc_cnt++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0]  frame[$];
    logic [15:0] exp_w[$];
    bit          exp_ok;
    int          exp_acc;

    // Reference: decode the frame by its rules alone
    task automatic model(input int aw);
        int         n;
        logic [7:0] x;
        n = int'({frame[0], frame[1]});
        exp_w.delete();
        x = 8'h00;
        if (n > (1 << aw)) begin
            exp_ok  = 1'b0;
            exp_acc = 2;
            return;
        end
        for (int i = 0; i < n; i++) exp_w.push_back({frame[2 + 2*i], frame[3 + 2*i]});
        for (int i = 0; i < frame.size() - 1; i++) x = x ^ frame[i];
        exp_ok  = (frame[frame.size() - 1] == x);
        exp_acc = frame.size();
    endtask

    task automatic build_frame(input int n, input bit good);
        logic [7:0] x;
        frame.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        for (int i = 0; i < 2*n; i++) frame.push_back(8'($urandom));
        x = 8'h00;
        foreach (frame[i]) x = x ^ frame[i];
        frame.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        rx_data  = b;
        rx_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge CLK);
            ok = c_rdy;
            @(posedge CLK); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        acc_cnt = 0;
    endtask

    task automatic run_frame(input logic s, input int aw, input bit gaps);
        bit ok;
        sel = s;
        model(aw);
        clear_log();
        pulse_start();
        @(negedge CLK);
        check("busy_after_start", c_busy, 1);
        check("cpu_rst_loading", c_cpu, 1);
        check("words_cleared", c_wl, 0);
        @(posedge CLK); #1;
        for (int i = 0; i < exp_acc; i++) begin
            send_byte(frame[i], ok);
            if (!ok) check("byte_accept_timeout", 0, 1);
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
        end
        for (int i = 0; i < 40 && c_busy; i++) @(negedge CLK);
        check("load_ends", c_busy, 0);
        check("done", c_done, exp_ok);
        check("err", c_err, !exp_ok);
        check("cpu_rst_after", c_cpu, !exp_ok);
        check("words_loaded", c_wl, exp_w.size());
        check("bytes_consumed", acc_cnt, exp_acc);
        check("n_writes", wr_addr.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_addr.size(); i++) begin
            check("wr_addr", wr_addr[i], i);
            check("wr_data", wr_data[i], exp_w[i]);
        end
    endtask

    initial begin
        bit ok;
        int cnt;

        #2;
        check("rst_rx_ready", c_rdy, 0);
        check("rst_mem_wr", wr_a, 0);
        check("rst_mem_addr", addr_a, 0);
        check("rst_mem_wdata", wd_a, 0);
        check("rst_cpu_rst", cr_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        check("rst_words", wl_a, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        check("idle_cpu_rst", cr_a, 0);
        check("idle_busy", busy_a, 0);
        @(posedge CLK); #1;

        frame = '{8'h00, 8'h02, 8'h40, 8'h41, 8'h12, 8'h34, 8'h25};
        run_frame(1'b0, 16, 1'b1);
        check("mem0", wr_data[0], 16'h4041);
        check("mem1", wr_data[1], 16'h1234);

        frame = '{8'h00, 8'h02, 8'h40, 8'h41, 8'h12, 8'h34, 8'h00};
        run_frame(1'b0, 16, 1'b0);
        check("badcsum_err", c_err, 1);

        frame = '{8'h00, 8'h00, 8'h00};
        run_frame(1'b0, 16, 1'b0);

        sel = 1'b0;
        clear_log();
        pulse_start();
        @(posedge CLK); #1;
        send_byte(8'h00, ok);
        send_byte(8'h01, ok);
        send_byte(8'h40, ok);
        cnt = 0;
        while (!c_err && cnt < 60) begin
            @(negedge CLK);
            cnt++;
        end
        check("timeout_err", c_err, 1);
        check("timeout_latency", cnt, TO + 1);
        check("timeout_cpu_rst", c_cpu, 1);
        check("timeout_no_write", wr_addr.size(), 0);
        @(posedge CLK); #1;

        frame = '{8'h00, 8'h11};
        run_frame(1'b1, 4, 1'b0);
        build_frame(16, 1'b1);
        run_frame(1'b1, 4, 1'b1);

        for (int k = 0; k < 6; k++) begin
            build_frame($urandom_range(0, 6), $urandom_range(0, 3) != 0);
            run_frame(1'b0, 16, 1'b1);
        end
        for (int k = 0; k < 2; k++) begin
            build_frame($urandom_range(1, 16), 1'b1);
            run_frame(1'b1, 4, 1'b1);
        end

        sel = 1'b0;
        clear_log();
        pulse_start();
        @(posedge CLK); #1;
        send_byte(8'h00, ok);
        send_byte(8'h02, ok);
        send_byte(8'hAA, ok);
        send_byte(8'hBB, ok);
        send_byte(8'hCC, ok);
        pulse_start();
        check("start_busy_ignored", c_wl, 1);
        check("start_busy_still", c_busy, 1);
        check("midload_one_write", wr_addr.size(), 1);
        #2;
        RST = 1'b1;
        #1;
        check("midrst_busy", c_busy, 0);
        check("midrst_cpu_rst", c_cpu, 0);
        check("midrst_rx_ready", c_rdy, 0);
        check("midrst_words", c_wl, 0);
        check("midrst_addr", c_addr, 0);
        check("midrst_wdata", c_wd, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("post_rst_cpu_rst", c_cpu, 0);
        check("post_rst_done", c_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
